// File: rtl/sift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sift_pkg
// Purpose  : Shared types and helpers for the keypoint collection path.
// Revision : 1.0 - initial release
// ============================================================================
package sift_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } kc_state_t;

    function automatic int coord_w(input int dim);
        return $clog2(dim);
    endfunction

    // Keep the low (cw - o) bits of an octave-o coordinate, optionally
    // shifting back to top-octave scale. Callers truncate to cw bits.
    function automatic logic [31:0] scale_coord(input logic [31:0] c, input int o,
                                                input int cw, input bit scale);
        logic [31:0] m;
        m = (o >= cw) ? 32'd0 : ((32'd1 << (cw - o)) - 32'd1);
        return scale ? ((c & m) << o) : (c & m);
    endfunction

    function automatic logic [31:0] pack_keypoint(input logic [31:0] oct, input logic [31:0] y,
                                                  input logic [31:0] x, input int cw);
        logic [31:0] m;
        m = (32'd1 << cw) - 32'd1;
        return (oct << (2 * cw)) | ((y & m) << cw) | (x & m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypoint_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : keypoint_rr_arbiter
// Purpose  : Combinational one-of-N grant, round-robin from ptr or fixed
//            lowest-index priority when mode is high.
// Revision : 1.0 - initial release
// ============================================================================
module keypoint_rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    always_comb begin
        int   start_i;
        int   k;
        logic found;
        grant   = '0;
        idx     = '0;
        found   = 1'b0;
        k       = 0;
        start_i = mode ? 0 : int'(ptr);
        for (int i = 0; i < N; i++) begin
            k = start_i + i;
            if (k >= N) k = k - N;
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = IW'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypoint_collector.sv
`default_nettype none
// ============================================================================
// Module   : keypoint_collector
// Purpose  : Merges per-octave keypoint streams into one BRAM write port,
//            tagging octave, enforcing capacity and signalling completion.
// Revision : 1.0 - initial release
// ============================================================================
module keypoint_collector
    import sift_pkg::*;
#(
    parameter int DIMENSION        = 64,
    parameter int NUMBER_OCTAVES   = 3,
    parameter int NUMBER_KEYPOINTS = 1000,
    parameter int ARB_MODE         = 0,
    parameter int SCALE_TO_TOP     = 0,
    localparam int CW = coord_w(DIMENSION),
    localparam int OW = (NUMBER_OCTAVES > 1) ? $clog2(NUMBER_OCTAVES) : 1,
    localparam int AW = $clog2(NUMBER_KEYPOINTS),
    localparam int NW = $clog2(NUMBER_KEYPOINTS + 1),
    localparam int KW = OW + 2 * CW
) (
    input  logic                         clk,
    input  logic                         rst_in,
    input  logic                         start,
    input  logic [NUMBER_OCTAVES-1:0]    oct_valid,
    output logic [NUMBER_OCTAVES-1:0]    oct_ready,
    input  logic [NUMBER_OCTAVES*CW-1:0] oct_x,
    input  logic [NUMBER_OCTAVES*CW-1:0] oct_y,
    input  logic [NUMBER_OCTAVES-1:0]    oct_done,
    output logic [AW-1:0]                key_write_addr,
    output logic                         key_wea,
    output logic [KW-1:0]                keypoint_out,
    output logic [NW-1:0]                key_count,
    output logic                         overflow,
    output logic                         busy,
    output logic                         keypoints_done
);

    localparam logic [NW-1:0] c_cap     = NW'(NUMBER_KEYPOINTS);
    localparam logic [NW-1:0] c_cap_m1  = NW'(NUMBER_KEYPOINTS - 1);
    localparam logic [OW-1:0] c_last_ch = OW'(NUMBER_OCTAVES - 1);

    kc_state_t                 r_state, w_state_next;
    logic [NUMBER_OCTAVES-1:0] r_done_lat;
    logic [NUMBER_OCTAVES-1:0] w_grant;
    logic [OW-1:0]             r_ptr, w_idx;
    logic                      r_pend;
    logic [KW-1:0]             r_data;
    logic [NW-1:0]             r_count;
    logic                      r_overflow;
    logic                      w_collect, w_start_pass, w_accept, w_full, w_write;
    logic [CW-1:0]             w_x_raw, w_y_raw;
    logic [KW-1:0]             w_packed;

    assign w_collect    = (r_state == COLLECT);
    assign w_start_pass = start && !w_collect;

    keypoint_rr_arbiter #(
        .N  (NUMBER_OCTAVES),
        .IW (OW)
    ) u_arb (
        .req   (oct_valid & {NUMBER_OCTAVES{w_collect}}),
        .ptr   (r_ptr),
        .mode  (ARB_MODE != 0),
        .grant (w_grant),
        .idx   (w_idx)
    );

    assign w_accept = |w_grant;
    // The pending write counts against capacity before it lands in r_count.
    assign w_full   = (r_count == c_cap) || (r_pend && (r_count == c_cap_m1));
    assign w_write  = w_accept && !w_full;

    assign w_x_raw  = oct_x[w_idx*CW +: CW];
    assign w_y_raw  = oct_y[w_idx*CW +: CW];
    assign w_packed = KW'(pack_keypoint(32'(w_idx),
                          scale_coord(32'(w_y_raw), int'(w_idx), CW, SCALE_TO_TOP != 0),
                          scale_coord(32'(w_x_raw), int'(w_idx), CW, SCALE_TO_TOP != 0),
                          CW));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = COLLECT;
            COLLECT: if ((&(r_done_lat | oct_done)) && !(|oct_valid) && !r_pend)
                         w_state_next = DONE;
            DONE:    if (start) w_state_next = COLLECT;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= IDLE;
            r_done_lat <= '0;
            r_ptr      <= '0;
            r_pend     <= 1'b0;
            r_data     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start_pass) begin
                r_done_lat <= '0;
                r_ptr      <= '0;
                r_pend     <= 1'b0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_collect) r_done_lat <= r_done_lat | oct_done;
                if (r_pend)    r_count    <= r_count + 1'b1;
                r_pend <= w_write;
                if (w_write) r_data <= w_packed;
                if (w_accept && w_full) r_overflow <= 1'b1;
                if (w_accept) r_ptr <= (w_idx == c_last_ch) ? '0 : w_idx + 1'b1;
            end
        end
    end

    assign oct_ready      = w_grant;
    assign key_wea        = r_pend;
    assign key_write_addr = r_count[AW-1:0];
    assign keypoint_out   = r_data;
    assign key_count      = r_count;
    assign overflow       = r_overflow;
    assign busy           = w_collect;
    assign keypoints_done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_keypoint_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypoint_collector
// Purpose  : Directed self-checking bench; instance A uses defaults, instance
//            B uses fixed priority, capacity 4 and top-level rescaling.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_keypoint_collector;

    logic clk    = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk = ~clk;

    logic        a_start, a_wea, a_ovf, a_busy, a_kd;
    logic [2:0]  a_valid, a_ready, a_done;
    logic [17:0] a_x, a_y;
    logic [9:0]  a_addr, a_count;
    logic [13:0] a_kp;

    logic        b_start, b_wea, b_ovf, b_busy, b_kd;
    logic [2:0]  b_valid, b_ready, b_done;
    logic [17:0] b_x, b_y;
    logic [1:0]  b_addr;
    logic [2:0]  b_count;
    logic [13:0] b_kp;

    keypoint_collector u_dut_a (
        .clk(clk), .rst_in(rst_in), .start(a_start),
        .oct_valid(a_valid), .oct_ready(a_ready), .oct_x(a_x), .oct_y(a_y), .oct_done(a_done),
        .key_write_addr(a_addr), .key_wea(a_wea), .keypoint_out(a_kp), .key_count(a_count),
        .overflow(a_ovf), .busy(a_busy), .keypoints_done(a_kd)
    );

    keypoint_collector #(
        .NUMBER_KEYPOINTS(4), .ARB_MODE(1), .SCALE_TO_TOP(1)
    ) u_dut_b (
        .clk(clk), .rst_in(rst_in), .start(b_start),
        .oct_valid(b_valid), .oct_ready(b_ready), .oct_x(b_x), .oct_y(b_y), .oct_done(b_done),
        .key_write_addr(b_addr), .key_wea(b_wea), .keypoint_out(b_kp), .key_count(b_count),
        .overflow(b_ovf), .busy(b_busy), .keypoints_done(b_kd)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) b_start = 1'b1; else a_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        a_start = 1'b0;
    endtask

    task automatic finish_pass(input bit sel, input string name);
        int k;
        @(negedge clk);
        if (sel) b_done = 3'b111; else a_done = 3'b111;
        @(negedge clk);
        b_done = 3'b000;
        a_done = 3'b000;
        #1;
        k = 0;
        while (!(sel ? b_kd : a_kd) && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, 32'(sel ? b_kd : a_kd), 32'd1);
    endtask

    typedef struct {
        logic [2:0] valid;
        logic [2:0] ready;
        logic       wea;
        logic [9:0] addr;
        int         oct;
    } vec_t;

    vec_t        vt[13];
    logic [13:0] nat_kp[3];
    logic [2:0]  fp_valid[4];
    logic [2:0]  fp_ready[4];
    logic [4:0]  ov_wea;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        a_start = 0; a_valid = 0; a_done = 0;
        b_start = 0; b_valid = 0; b_done = 0;
        a_x = {6'd60, 6'd10, 6'd3};
        a_y = {6'd20, 6'd20, 6'd5};
        b_x = {6'd7, 6'd5, 6'd1};
        b_y = {6'd9, 6'd6, 6'd1};

        // {oct, y, x} for each channel of A after masking to CW-o bits
        nat_kp[0] = 14'h0143;
        nat_kp[1] = 14'h150A;
        nat_kp[2] = 14'h210C;

        vt[0]  = '{3'b111, 3'b001, 1'b0, 10'd0,  0};
        vt[1]  = '{3'b111, 3'b010, 1'b1, 10'd0,  0};
        vt[2]  = '{3'b111, 3'b100, 1'b1, 10'd1,  1};
        vt[3]  = '{3'b111, 3'b001, 1'b1, 10'd2,  2};
        vt[4]  = '{3'b111, 3'b010, 1'b1, 10'd3,  0};
        vt[5]  = '{3'b111, 3'b100, 1'b1, 10'd4,  1};
        vt[6]  = '{3'b110, 3'b010, 1'b1, 10'd5,  2};
        vt[7]  = '{3'b011, 3'b001, 1'b1, 10'd6,  1};
        vt[8]  = '{3'b101, 3'b100, 1'b1, 10'd7,  0};
        vt[9]  = '{3'b000, 3'b000, 1'b1, 10'd8,  2};
        vt[10] = '{3'b100, 3'b100, 1'b0, 10'd0,  0};
        vt[11] = '{3'b010, 3'b010, 1'b1, 10'd9,  2};
        vt[12] = '{3'b000, 3'b000, 1'b1, 10'd10, 1};

        fp_valid = '{3'b111, 3'b111, 3'b110, 3'b100};
        fp_ready = '{3'b001, 3'b001, 3'b010, 3'b100};
        ov_wea   = 5'b01111;

        // Reset values
        #2 rst_in = 1'b0;
        #1;
        check("rst_wea",   32'(a_wea),   0);
        check("rst_ready", 32'(a_ready), 0);
        check("rst_busy",  32'(a_busy),  0);
        check("rst_done",  32'(a_kd),    0);
        check("rst_count", 32'(a_count), 0);
        check("rst_kp",    32'(a_kp),    0);
        check("rst_ovf",   32'(b_ovf),   0);
        @(negedge clk);
        rst_in = 1'b1;

        // Single beat with all channels done on the same cycle
        pulse_start(1'b0);
        #1 check("t1_busy", 32'(a_busy), 1);
        a_valid = 3'b001;
        a_done  = 3'b111;
        #1 check("t1_ready", 32'(a_ready), 32'b001);
        @(negedge clk);
        a_valid = 0;
        a_done  = 0;
        #1;
        check("t1_wea",  32'(a_wea),  1);
        check("t1_addr", 32'(a_addr), 0);
        check("t1_kp",   32'(a_kp),   32'h0143);
        check("t1_kd_early", 32'(a_kd), 0);
        @(negedge clk);
        #1;
        check("t1_count", 32'(a_count), 1);
        check("t1_wea_pulse", 32'(a_wea), 0);
        check("t1_kd_wait", 32'(a_kd), 0);
        @(negedge clk);
        #1;
        check("t1_kd", 32'(a_kd), 1);
        check("t1_idle_busy", 32'(a_busy), 0);

        // Round-robin table, restarting from DONE
        pulse_start(1'b0);
        #1;
        check("t2_count_clr", 32'(a_count), 0);
        check("t2_busy", 32'(a_busy), 1);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            a_valid = vt[i].valid;
            #1;
            check($sformatf("rr_ready[%0d]", i), 32'(a_ready), 32'(vt[i].ready));
            check($sformatf("rr_wea[%0d]", i),   32'(a_wea),   32'(vt[i].wea));
            if (vt[i].wea) begin
                check($sformatf("rr_addr[%0d]", i), 32'(a_addr), 32'(vt[i].addr));
                check($sformatf("rr_kp[%0d]", i),   32'(a_kp),   32'(nat_kp[vt[i].oct]));
            end
        end
        @(negedge clk);
        #1 check("t2_count", 32'(a_count), 11);
        finish_pass(1'b0, "t2_kd");

        // Asynchronous reset in the middle of a burst
        pulse_start(1'b0);
        a_valid = 3'b111;
        @(negedge clk);
        @(negedge clk);
        #1 check("t6_pre_wea", 32'(a_wea), 1);
        #1 rst_in = 1'b0;
        #1;
        check("t6_wea",   32'(a_wea),   0);
        check("t6_ready", 32'(a_ready), 0);
        check("t6_busy",  32'(a_busy),  0);
        check("t6_count", 32'(a_count), 0);
        check("t6_addr",  32'(a_addr),  0);
        check("t6_kp",    32'(a_kp),    0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1 check($sformatf("t6_hold_wea[%0d]", i), 32'(a_wea), 0);
        end
        rst_in = 1'b1;
        @(negedge clk);
        #1;
        check("t6_idle_ready", 32'(a_ready), 0);
        check("t6_idle_wea", 32'(a_wea), 0);
        a_valid = 0;
        pulse_start(1'b0);
        a_valid = 3'b001;
        @(negedge clk);
        a_valid = 0;
        #1;
        check("t6_fresh_wea",  32'(a_wea),  1);
        check("t6_fresh_addr", 32'(a_addr), 0);
        @(negedge clk);
        #1 check("t6_fresh_count", 32'(a_count), 1);

        // Fixed priority on instance B
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_valid = fp_valid[i];
            #1 check($sformatf("fp_ready[%0d]", i), 32'(b_ready), 32'(fp_ready[i]));
        end
        @(negedge clk);
        b_valid = 0;
        finish_pass(1'b1, "t3_kd");
        check("t3_count", 32'(b_count), 4);
        check("t3_ovf",   32'(b_ovf),   0);

        // Capacity 4, six beats on channel 1
        pulse_start(1'b1);
        #1;
        check("t4_count_clr", 32'(b_count), 0);
        check("t4_ovf_clr",   32'(b_ovf),   0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b_valid = 3'b010;
            #1;
            check($sformatf("ov_ready[%0d]", i), 32'(b_ready), 32'b010);
            if (i > 0) begin
                check($sformatf("ov_wea[%0d]", i), 32'(b_wea), 32'(ov_wea[i-1]));
                if (ov_wea[i-1]) check($sformatf("ov_addr[%0d]", i), 32'(b_addr), 32'(i - 1));
                if (i == 1) check("ov_kp", 32'(b_kp), 32'h130A);
            end
        end
        @(negedge clk);
        b_valid = 0;
        #1;
        check("ov_wea_last", 32'(b_wea),   0);
        check("ov_ovf",      32'(b_ovf),   1);
        check("ov_count",    32'(b_count), 4);
        finish_pass(1'b1, "t4_kd");

        // Rescaled coordinates from octave 2
        pulse_start(1'b1);
        b_valid = 3'b100;
        @(negedge clk);
        b_valid = 0;
        #1;
        check("t5_wea", 32'(b_wea), 1);
        check("t5_kp",  32'(b_kp),  32'h291C);
        @(negedge clk);
        #1 check("t5_count", 32'(b_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
